// File: rtl/mux4_source_arbiter_if.sv
// Handshake bundle between the mux4 source arbiter and its requesters.
// master: requester side (req, manual); slave: arbiter side (ctrl, grant).
interface mux4_source_arbiter_if;
  logic [3:0] req;
  logic       manual_en;
  logic [1:0] manual_sel;
  logic [1:0] ctrl;
  logic [3:0] grant;
  logic       switch_pulse;
  logic       busy;

  modport master (
    output req, manual_en, manual_sel,
    input  ctrl, grant, switch_pulse, busy
  );

  modport slave (
    input  req, manual_en, manual_sel,
    output ctrl, grant, switch_pulse, busy
  );
endinterface

// File: rtl/mux4_source_arbiter.sv
// Round-robin arbiter with min dwell and manual override for mux4.
// Ports: clk, reset (sync, active-high), bus (slave: req/manual in, ctrl/grant/pulse/busy out).
module mux4_source_arbiter #(
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int CNT_W        = $clog2(DWELL_CYCLES + 1)
) (
  input logic                  clk,
  input logic                  reset,
  mux4_source_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_MANUAL = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_ONE     = CNT_W'(1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_last;
  logic [1:0]       r_ctrl;
  logic [3:0]       r_grant;
  logic             r_pulse;
  logic             r_busy;

  state_t           w_nxt_state;
  logic [CNT_W-1:0] w_nxt_cnt;
  logic [1:0]       w_nxt_last;
  logic [1:0]       w_nxt_ctrl;
  logic [3:0]       w_nxt_grant;

  logic [7:0]       w_dbl;
  logic [2:0]       w_base;
  logic [3:0]       w_rot;
  logic [1:0]       w_off;
  logic [1:0]       w_pick;
  logic             w_any;
  logic             w_other;

  // Rotate req so bit 0 is source last+1; first set bit wins.
  assign w_dbl  = {bus.req, bus.req};
  assign w_base = {1'b0, r_last} + 3'd1;
  assign w_rot  = w_dbl[w_base +: 4];

  always_comb begin
    w_off = 2'd3;
    if (w_rot[0])      w_off = 2'd0;
    else if (w_rot[1]) w_off = 2'd1;
    else if (w_rot[2]) w_off = 2'd2;
  end

  assign w_pick  = r_last + 2'd1 + w_off;
  assign w_any   = |bus.req;
  assign w_other = |(bus.req & ~(4'b0001 << r_last));

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_last  = r_last;
    w_nxt_ctrl  = r_ctrl;
    w_nxt_grant = r_grant;
    unique case (r_state)
      ST_IDLE: begin
        w_nxt_grant = 4'b0000;
        if (bus.manual_en) begin
          w_nxt_state = ST_MANUAL;
          w_nxt_ctrl  = bus.manual_sel;
        end else if (w_any) begin
          w_nxt_state = ST_GRANT;
          w_nxt_ctrl  = w_pick;
          w_nxt_grant = 4'b0001 << w_pick;
          w_nxt_last  = w_pick;
          w_nxt_cnt   = '0;
        end
      end
      ST_GRANT: begin
        if (bus.manual_en) begin
          w_nxt_state = ST_MANUAL;
          w_nxt_ctrl  = bus.manual_sel;
          w_nxt_grant = 4'b0000;
        end else if (r_cnt != LP_CNT_MAX) begin
          w_nxt_cnt = r_cnt + LP_ONE;
        end else if (w_other) begin
          w_nxt_ctrl  = w_pick;
          w_nxt_grant = 4'b0001 << w_pick;
          w_nxt_last  = w_pick;
          w_nxt_cnt   = '0;
        end else if (!bus.req[r_last]) begin
          w_nxt_state = ST_IDLE;
          w_nxt_grant = 4'b0000;
        end
      end
      ST_MANUAL: begin
        w_nxt_grant = 4'b0000;
        if (bus.manual_en) begin
          w_nxt_ctrl = bus.manual_sel;
        end else begin
          w_nxt_state = ST_IDLE;
        end
      end
      default: begin
        w_nxt_state = ST_IDLE;
        w_nxt_grant = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_last  <= 2'd3;
      r_ctrl  <= 2'd0;
      r_grant <= 4'b0000;
      r_pulse <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
      r_last  <= w_nxt_last;
      r_ctrl  <= w_nxt_ctrl;
      r_grant <= w_nxt_grant;
      r_pulse <= (w_nxt_ctrl != r_ctrl) ||
                 (w_nxt_grant != r_grant);
      r_busy  <= (w_nxt_state != ST_IDLE);
    end
  end

  assign bus.ctrl         = r_ctrl;
  assign bus.grant        = r_grant;
  assign bus.switch_pulse = r_pulse;
  assign bus.busy         = r_busy;

endmodule
